// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-addressed RAM. Independent read and write FSMs serve
// FIXED/INCR bursts of up to 16 beats and report DECERR/SLVERR per beat.
module axi_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  // Handshakes: a beat transfers on the rising edge where valid && ready are both high.
  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS) * 32'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH_WORDS];

  // Out-of-range beats win over malformed size/burst; WRAP and reserved both have burst[1] set.
  function automatic logic [1:0] beat_code(input logic [31:0] addr, input logic [2:0] size,
                                           input logic [1:0] burst);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    if (off >= SPAN) return RESP_DECERR;
    if (size > 3'd2 || burst[1]) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b01) ? addr + (32'd1 << size) : addr;
  endfunction

  // Response codes are ordered so that the numerically larger one has priority.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // ---------------- read channel ----------------
  r_state_t    r_state, r_state_nxt;
  logic [3:0]  r_id, r_len, r_cnt;
  logic [31:0] r_addr, r_off;
  logic [2:0]  r_size;
  logic [1:0]  r_burst, r_code;
  logic [IDX_W-1:0] r_idx;

  assign r_off  = r_addr - ADDR_BASE;
  assign r_idx  = r_off[IDX_W+1:2];
  assign r_code = beat_code(r_addr, r_size, r_burst);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE: if (arvalid) r_state_nxt = R_DATA;
      R_DATA: if (rready && r_cnt == r_len) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
    rlast   = rvalid && (r_cnt == r_len);
    rresp   = rvalid ? r_code : RESP_OKAY;
    rdata   = (rvalid && r_code == RESP_OKAY) ? mem[r_idx] : 32'h0;
    rid     = r_id;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
    end else if (r_state == R_IDLE && arvalid) begin
      r_id    <= arid;
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
      r_cnt   <= '0;
    end else if (r_state == R_DATA && rready) begin
      r_addr  <= next_addr(r_addr, r_size, r_burst);
      r_cnt   <= r_cnt + 4'd1;
    end
  end

  // ---------------- write channel ----------------
  w_state_t    w_state, w_state_nxt;
  logic [3:0]  w_id, w_len, w_cnt;
  logic [31:0] w_addr, w_off;
  logic [2:0]  w_size;
  logic [1:0]  w_burst, w_code, w_err, w_beat_err;
  logic [IDX_W-1:0] w_idx;
  logic        w_fire, w_final, w_en;

  assign w_off      = w_addr - ADDR_BASE;
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_code     = beat_code(w_addr, w_size, w_burst);
  assign w_fire     = (w_state == W_DATA) && wvalid;
  assign w_final    = (w_cnt == w_len);
  // A misplaced wlast flags the burst but the beat's data is still stored.
  assign w_beat_err = worst(w_code, (wlast != w_final) ? RESP_SLVERR : RESP_OKAY);
  assign w_en       = w_fire && (w_code == RESP_OKAY);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE: if (awvalid) w_state_nxt = W_DATA;
      W_DATA: if (wvalid && w_final) w_state_nxt = W_RESP;
      W_RESP: if (bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
    bresp   = bvalid ? w_err : RESP_OKAY;
    bid     = w_id;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= RESP_OKAY;
    end else if (w_state == W_IDLE && awvalid) begin
      w_id    <= awid;
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
      w_cnt   <= '0;
      w_err   <= RESP_OKAY;
    end else if (w_fire) begin
      w_addr  <= next_addr(w_addr, w_size, w_burst);
      w_cnt   <= w_cnt + 4'd1;
      w_err   <= worst(w_err, w_beat_err);
    end
  end

  always_ff @(posedge aclk) begin
    if (w_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                         r_off[31:IDX_W+2], r_off[1:0], w_off[31:IDX_W+2], w_off[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: hand-computed expectations for reset, bursts,
// strobes, error responses, same-word read/write and asynchronous reset mid-burst.
module tb_axi_sram_slave;

  logic        aclk, aresetn;
  logic [3:0]  arid, arlen, awid, awlen, wid, wstrb, arcache, awcache;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic        arvalid, awvalid, wlast, wvalid, rready, bready;
  logic        arready, rlast, rvalid, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  int vectors = 0;
  int miscompares = 0;
  localparam int BOUND = 20;

  axi_sram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // clock / reset
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!awready && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) check("awready_timeout", 32'd0, 32'd1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!wready && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) check("wready_timeout", 32'd0, 32'd1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic get_b(input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    while (!bvalid && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) check("bvalid_timeout", 32'd0, 32'd1);
    check("bid", bid, id);
    check("bresp", bresp, resp);
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (!arready && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) check("arready_timeout", 32'd0, 32'd1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic get_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                       input logic last, input logic stall);
    int n = 0;
    while (!rvalid && n < BOUND) begin tick(); n++; end
    if (n >= BOUND) check("rvalid_timeout", 32'd0, 32'd1);
    if (stall) begin
      rready = 1'b0;
      check("rdata_pre_stall", rdata, data);
      tick();
      check("rdata_held", rdata, data);
      check("rvalid_held", rvalid, 1'b1);
    end
    check("rid", rid, id);
    check("rdata", rdata, data);
    check("rresp", rresp, resp);
    check("rlast", rlast, last);
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic write_word(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
    send_aw(id, addr, 4'd0, 3'd2, 2'b01);
    send_w(data, strb, 1'b1);
    get_b(id, 2'b00);
  endtask

  // scoreboard-free directed sequence: every expected value is a literal below
  initial begin
    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

    repeat (2) tick();
    check("rst_arready", arready, 1'b1);
    check("rst_awready", awready, 1'b1);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rlast", rlast, 1'b0);
    check("rst_rid", rid, 4'd0);
    check("rst_bid", bid, 4'd0);
    check("rst_rresp", rresp, 2'b00);
    check("rst_bresp", bresp, 2'b00);
    aresetn = 1'b1;
    tick();

    // W before AW is held off
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wlast = 1'b1;
    tick();
    check("w_holdoff", wready, 1'b0);
    wvalid = 1'b0;

    // single write then read
    send_aw(4'd3, 32'h10, 4'd0, 3'd2, 2'b01);
    send_w(32'hDEAD_BEEF, 4'hF, 1'b1);
    check("b_latency", bvalid, 1'b1);
    get_b(4'd3, 2'b00);
    send_ar(4'd5, 32'h10, 4'd0, 3'd2, 2'b01);
    check("r_latency", rvalid, 1'b1);
    get_r(4'd5, 32'hDEAD_BEEF, 2'b00, 1'b1, 1'b0);

    // INCR burst with read backpressure on alternate beats
    send_aw(4'd1, 32'h100, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) send_w(32'(i), 4'hF, i == 3);
    get_b(4'd1, 2'b00);
    send_ar(4'd2, 32'h100, 4'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) get_r(4'd2, 32'(i), 2'b00, i == 3, i % 2 == 1);

    // FIXED burst re-reads the same word
    send_ar(4'd4, 32'h104, 4'd2, 3'd2, 2'b00);
    for (int i = 0; i < 3; i++) get_r(4'd4, 32'd1, 2'b00, i == 2, 1'b0);

    // byte strobes
    write_word(4'd6, 32'h0, 32'h0, 4'hF);
    write_word(4'd6, 32'h0, 32'hAABB_CCDD, 4'b0101);
    send_ar(4'd7, 32'h0, 4'd0, 3'd2, 2'b01);
    get_r(4'd7, 32'h00BB_00DD, 2'b00, 1'b1, 1'b0);

    // DECERR read and write just past the end
    send_ar(4'd6, 32'h4000, 4'd0, 3'd2, 2'b01);
    get_r(4'd6, 32'h0, 2'b11, 1'b1, 1'b0);
    send_aw(4'd7, 32'h4000, 4'd0, 3'd2, 2'b01);
    send_w(32'h5555_5555, 4'hF, 1'b1);
    get_b(4'd7, 2'b11);

    // early wlast: both beats accepted and written, SLVERR reported
    send_aw(4'd8, 32'h20, 4'd1, 3'd2, 2'b01);
    send_w(32'hA0, 4'hF, 1'b1);
    send_w(32'hA1, 4'hF, 1'b1);
    get_b(4'd8, 2'b10);
    send_ar(4'd8, 32'h20, 4'd1, 3'd2, 2'b01);
    get_r(4'd8, 32'hA0, 2'b00, 1'b0, 1'b0);
    get_r(4'd8, 32'hA1, 2'b00, 1'b1, 1'b0);

    // WRAP read: SLVERR on every beat
    send_ar(4'd9, 32'h20, 4'd1, 3'd2, 2'b10);
    get_r(4'd9, 32'h0, 2'b10, 1'b0, 1'b0);
    get_r(4'd9, 32'h0, 2'b10, 1'b1, 1'b0);

    // oversize write suppressed
    send_aw(4'd10, 32'h10, 4'd0, 3'd3, 2'b01);
    send_w(32'h1234_5678, 4'hF, 1'b1);
    get_b(4'd10, 2'b10);
    send_ar(4'd10, 32'h10, 4'd0, 3'd2, 2'b01);
    get_r(4'd10, 32'hDEAD_BEEF, 2'b00, 1'b1, 1'b0);

    // AR and AW to the same word in the same cycle
    write_word(4'd11, 32'h30, 32'h1111_1111, 4'hF);
    arid = 4'd11; araddr = 32'h30; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'd12; awaddr = 32'h30; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    check("cc_arready", arready, 1'b1);
    check("cc_awready", awready, 1'b1);
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    wdata = 32'h2222_2222; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    check("cc_wready", wready, 1'b1);
    check("cc_rdata_old", rdata, 32'h1111_1111);
    tick();
    wvalid = 1'b0;
    check("cc_rdata_new", rdata, 32'h2222_2222);
    check("cc_bvalid", bvalid, 1'b1);
    get_r(4'd11, 32'h2222_2222, 2'b00, 1'b1, 1'b0);
    get_b(4'd12, 2'b00);

    // asynchronous reset in the middle of a read burst
    send_ar(4'd13, 32'h100, 4'd3, 3'd2, 2'b01);
    get_r(4'd13, 32'd0, 2'b00, 1'b0, 1'b0);
    #1 aresetn = 1'b0;
    #1;
    check("arst_rvalid", rvalid, 1'b0);
    check("arst_arready", arready, 1'b1);
    check("arst_awready", awready, 1'b1);
    check("arst_rlast", rlast, 1'b0);
    tick();
    aresetn = 1'b1;
    tick();
    check("post_rst_rvalid", rvalid, 1'b0);
    send_ar(4'd14, 32'h104, 4'd0, 3'd2, 2'b01);
    get_r(4'd14, 32'd1, 2'b00, 1'b1, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
